// File: rtl/present_sbox_layer_ctrl.sv
// PRESENT substitution-layer sequencer for a 2-share masked 64-bit state.
// Feeds one external masked S-box nibble by nibble. Each nibble uses one fresh
// random bit, and issue stalls while no randomness is offered. The block
// collects the S-box outputs after SBOX_LAT cycles and rebuilds both output
// shares. The two shares are routed separately and never XORed together here.
module present_sbox_layer_ctrl #(
  parameter int unsigned SBOX_LAT = 3,
  parameter int unsigned NIB      = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [63:0] state_in_0,
  input  logic [63:0] state_in_1,
  input  logic        rnd,
  input  logic        rnd_valid,
  output logic        rnd_ready,
  output logic [3:0]  sb_x_0,
  output logic [3:0]  sb_x_1,
  output logic        sb_r,
  input  logic [3:0]  sb_y_0,
  input  logic [3:0]  sb_y_1,
  output logic        busy,
  output logic        done,
  output logic [63:0] state_out_0,
  output logic [63:0] state_out_1
);

  localparam int unsigned IW = $clog2(NIB);
  localparam int unsigned CW = $clog2(NIB + 1);
  // One pipeline entry holds a valid flag and a nibble index.
  localparam int unsigned PE = IW + 1;
  localparam int unsigned PW = SBOX_LAT * PE;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t        state;
  state_t        state_nxt;

  logic [63:0]   lat_0;
  logic [63:0]   lat_1;
  logic [63:0]   res_0;
  logic [63:0]   res_1;
  logic [63:0]   res_0_nxt;
  logic [63:0]   res_1_nxt;

  logic [IW-1:0] issue_cnt;
  logic [CW-1:0] collect_cnt;
  logic [CW-1:0] collect_nxt;

  // Packed shift pipeline. The newest entry sits in the low PE bits and the
  // entry that leaves after SBOX_LAT cycles sits in the top PE bits.
  logic [PW-1:0] pipe;
  logic [PW-1:0] pipe_nxt;
  logic [PE-1:0] pipe_top;

  logic          issue_fire;
  logic          last_issue;
  logic          cap_fire;
  logic [IW-1:0] cap_idx;
  logic          load;

  // Issue/collect handshakes derived from the current phase.
  always_comb begin
    issue_fire  = (state == S_ISSUE) && rnd_valid;
    last_issue  = issue_fire && (issue_cnt == IW'(NIB - 1));
    pipe_top    = pipe[PW-1 -: PE];
    cap_idx     = pipe_top[IW-1:0];
    cap_fire    = pipe_top[PE-1] && ((state == S_ISSUE) || (state == S_DRAIN));
    collect_nxt = collect_cnt + {{(CW-1){1'b0}}, cap_fire};
    pipe_nxt    = (pipe << PE) | PW'({issue_fire, issue_cnt});
    load        = (state == S_IDLE) && start;
  end

  // Drive the S-box only on a real issue. Bubble cycles carry all-zero shares.
  always_comb begin
    rnd_ready = issue_fire;
    sb_r      = issue_fire & rnd;
    sb_x_0    = '0;
    sb_x_1    = '0;
    if (issue_fire) begin
      sb_x_0 = lat_0[{issue_cnt, 2'b00} +: 4];
      sb_x_1 = lat_1[{issue_cnt, 2'b00} +: 4];
    end
    busy = (state != S_IDLE);
    done = (state == S_DONE);
  end

  // Merge this cycle's captured output nibble into the working result.
  always_comb begin
    res_0_nxt = res_0;
    res_1_nxt = res_1;
    if (cap_fire) begin
      res_0_nxt[{cap_idx, 2'b00} +: 4] = sb_y_0;
      res_1_nxt[{cap_idx, 2'b00} +: 4] = sb_y_1;
    end
  end

  // Next-state logic for the sequencer.
  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE:  if (start) state_nxt = S_ISSUE;
      S_ISSUE: if (last_issue) state_nxt = S_DRAIN;
      S_DRAIN: if (collect_nxt == CW'(NIB)) state_nxt = S_DONE;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Latch the input shares at start. Start is ignored outside IDLE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lat_0 <= '0;
      lat_1 <= '0;
    end else if (load) begin
      lat_0 <= state_in_0;
      lat_1 <= state_in_1;
    end
  end

  // Issue counter. It wraps to 0 after the last nibble and is reloaded at start.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      issue_cnt <= '0;
    end else if (load) begin
      issue_cnt <= '0;
    end else if (issue_fire) begin
      issue_cnt <= issue_cnt + 1'b1;
    end
  end

  // Valid/index pipeline that tracks the S-box latency. Bubbles push an invalid entry.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pipe <= '0;
    end else begin
      pipe <= pipe_nxt;
    end
  end

  // Collection: count the captured nibbles and build the working result.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      collect_cnt <= '0;
      res_0       <= '0;
      res_1       <= '0;
    end else if (load) begin
      collect_cnt <= '0;
      res_0       <= '0;
      res_1       <= '0;
    end else begin
      collect_cnt <= collect_nxt;
      res_0       <= res_0_nxt;
      res_1       <= res_1_nxt;
    end
  end

  // Publish the result only on entry to DONE. The final nibble is captured at
  // that same edge, so the merged value is taken here rather than res_0/res_1.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_out_0 <= '0;
      state_out_1 <= '0;
    end else if ((state == S_DRAIN) && (state_nxt == S_DONE)) begin
      state_out_0 <= res_0_nxt;
      state_out_1 <= res_1_nxt;
    end
  end

endmodule

// File: tb/tb_present_sbox_layer_ctrl.sv
// Self-checking bench for present_sbox_layer_ctrl. A stand-in masked S-box
// with a 3-cycle latency is attached. A cycle-level reference model, built from
// counts and timestamps, checks the outputs on every negative edge.
module tb_present_sbox_layer_ctrl;

  localparam int unsigned LAT = 3;
  localparam logic [63:0] ID_IN    = 64'hFEDCBA9876543210;
  localparam logic [63:0] ID_RES   = 64'h21748FE3DA09B65C;
  localparam logic [63:0] ZERO_RES = 64'hCCCCCCCCCCCCCCCC;

  logic        clk = 1'b0;
  logic        rst, start, rnd, rnd_valid, rnd_ready, sb_r, busy, done;
  logic [63:0] state_in_0, state_in_1, state_out_0, state_out_1;
  logic [3:0]  sb_x_0, sb_x_1, sb_y_0, sb_y_1;

  int compared   = 0;
  int mismatched = 0;

  always #5 clk = ~clk;

  present_sbox_layer_ctrl #(.SBOX_LAT(LAT)) dut (
    .clk(clk), .rst(rst), .start(start),
    .state_in_0(state_in_0), .state_in_1(state_in_1),
    .rnd(rnd), .rnd_valid(rnd_valid), .rnd_ready(rnd_ready),
    .sb_x_0(sb_x_0), .sb_x_1(sb_x_1), .sb_r(sb_r),
    .sb_y_0(sb_y_0), .sb_y_1(sb_y_1),
    .busy(busy), .done(done),
    .state_out_0(state_out_0), .state_out_1(state_out_1)
  );

  function automatic logic [3:0] sbox4(input logic [3:0] v);
    case (v)
      4'h0: return 4'hC; 4'h1: return 4'h5; 4'h2: return 4'h6; 4'h3: return 4'hB;
      4'h4: return 4'h9; 4'h5: return 4'h0; 4'h6: return 4'hA; 4'h7: return 4'hD;
      4'h8: return 4'h3; 4'h9: return 4'hE; 4'hA: return 4'hF; 4'hB: return 4'h8;
      4'hC: return 4'h4; 4'hD: return 4'h7; 4'hE: return 4'h1; default: return 4'h2;
    endcase
  endfunction

  // Output sharing of the stand-in S-box: y1 = x1 ^ rrrr, y0 = S(x0^x1) ^ y1.
  function automatic logic [3:0] y1_of(input logic [3:0] x1, input logic r);
    return x1 ^ {4{r}};
  endfunction
  function automatic logic [3:0] y0_of(input logic [3:0] x0, input logic [3:0] x1, input logic r);
    return sbox4(x0 ^ x1) ^ y1_of(x1, r);
  endfunction

  // Stand-in external S-box: LAT register stages from sb_x/sb_r to sb_y.
  logic [3:0] pv0 [LAT];
  logic [3:0] pv1 [LAT];
  always @(posedge clk) begin
    pv0[0] <= y0_of(sb_x_0, sb_x_1, sb_r);
    pv1[0] <= y1_of(sb_x_1, sb_r);
    for (int k = 1; k < LAT; k++) begin
      pv0[k] <= pv0[k-1];
      pv1[k] <= pv1[k-1];
    end
  end
  assign sb_y_0 = pv0[LAT-1];
  assign sb_y_1 = pv1[LAT-1];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model state. mc is the index of the current cycle.
  int          mc        = 0;
  bit          m_active  = 0;
  int          m_issued  = 0;
  int          m_done_c  = -1;
  logic [63:0] m_lat0 = '0, m_lat1 = '0, m_acc0 = '0, m_acc1 = '0;
  logic [63:0] m_out0 = '0, m_out1 = '0;

  // Advance the model over the cycle that has just ended, using that cycle's inputs.
  task automatic model_edge();
    logic [3:0] x0, x1;
    if (rst) begin
      m_active = 0; m_issued = 0; m_done_c = -1;
      m_out0 = '0; m_out1 = '0;
    end else if (!m_active) begin
      if (start) begin
        m_active = 1; m_issued = 0; m_done_c = -1;
        m_lat0 = state_in_0; m_lat1 = state_in_1;
        m_acc0 = '0; m_acc1 = '0;
      end
    end else if (mc == m_done_c) begin
      m_active = 0;
    end else begin
      if (m_issued < 16 && rnd_valid) begin
        x0 = 4'(m_lat0 >> (4 * m_issued));
        x1 = 4'(m_lat1 >> (4 * m_issued));
        m_acc0 |= 64'(y0_of(x0, x1, rnd)) << (4 * m_issued);
        m_acc1 |= 64'(y1_of(x1, rnd)) << (4 * m_issued);
        m_issued++;
        if (m_issued == 16) m_done_c = mc + LAT + 1;
      end
      if (m_done_c == mc + 1) begin
        m_out0 = m_acc0;
        m_out1 = m_acc1;
      end
    end
    mc++;
  endtask

  // Per-cycle comparison of every output against the model.
  initial begin
    logic       e_busy, e_done, e_rdy, e_r;
    logic [3:0] e_x0, e_x1;
    forever begin
      @(negedge clk);
      if (rst) begin
        e_busy = 0; e_done = 0; e_rdy = 0; e_r = 0; e_x0 = '0; e_x1 = '0;
        chk("out0", state_out_0, 64'h0);
        chk("out1", state_out_1, 64'h0);
      end else begin
        e_busy = m_active;
        e_done = m_active && (mc == m_done_c);
        e_rdy  = m_active && (m_issued < 16) && rnd_valid;
        e_r    = e_rdy & rnd;
        e_x0   = e_rdy ? 4'(m_lat0 >> (4 * m_issued)) : 4'h0;
        e_x1   = e_rdy ? 4'(m_lat1 >> (4 * m_issued)) : 4'h0;
        chk("out0", state_out_0, m_out0);
        chk("out1", state_out_1, m_out1);
      end
      chk("busy", 64'(busy), 64'(e_busy));
      chk("done", 64'(done), 64'(e_done));
      chk("rnd_ready", 64'(rnd_ready), 64'(e_rdy));
      chk("sb_r", 64'(sb_r), 64'(e_r));
      chk("sb_x_0", 64'(sb_x_0), 64'(e_x0));
      chk("sb_x_1", 64'(sb_x_1), 64'(e_x1));
    end
  end

  int mode  = 0;   // 0 always valid, 1 pattern 1001, 2 random, 3 toggle
  bit rzero = 0;
  int phase = 0;

  // Advance one cycle: update the model at the edge, then drive the new inputs.
  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    start = 1'b0;
    case (mode)
      0:       rnd_valid = 1'b1;
      1:       rnd_valid = ((phase % 4) == 0) || ((phase % 4) == 3);
      2:       rnd_valid = ($urandom_range(0, 2) != 0);
      default: rnd_valid = ((phase % 2) == 0);
    endcase
    rnd = rzero ? 1'b0 : 1'($urandom_range(0, 1));
    phase++;
    #1;
  endtask

  // Run one operation. An exp_rel below 0 means 20 plus the bubbles counted here.
  task automatic do_op(input logic [63:0] a, input logic [63:0] b, input int m,
                       input bit zr, input bit poke, input int exp_rel,
                       input bit chk_x, input logic [63:0] exp_x);
    int rel, pulses, bub;
    bit seen;
    mode = m; rzero = zr;
    step();
    start = 1'b1; state_in_0 = a; state_in_1 = b;
    phase = 0; rel = 0; pulses = 0; bub = 0; seen = 0;
    while (!seen && rel < 400) begin
      step();
      rel++;
      if (rnd_ready) pulses++;
      if (m_active && m_issued < 16 && !rnd_valid) bub++;
      if (poke && rel == 5) begin
        start = 1'b1; state_in_0 = ~a; state_in_1 = a;
      end
      if (done) begin
        seen = 1;
        if (poke) begin
          start = 1'b1; state_in_0 = {$urandom, $urandom}; state_in_1 = '0;
        end
      end
    end
    if (!seen) begin
      mismatched++;
      $display("FAIL done_timeout: got no done within %0d cycles, required one", rel);
    end
    chk("done_cycle", 64'(rel), 64'((exp_rel < 0) ? (20 + bub) : exp_rel));
    chk("rnd_ready_pulses", 64'(pulses), 64'd16);
    if (chk_x) chk("share_xor", state_out_0 ^ state_out_1, exp_x);
  endtask

  initial begin
    logic [63:0] msk;
    bit d_seen;
    #200000;
    mismatched++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    logic [63:0] msk;
    bit d_seen;
    rst = 1'b1; start = 1'b0; state_in_0 = '0; state_in_1 = '0;
    rnd = 1'b0; rnd_valid = 1'b0;
    step(); step();
    chk("reset_busy", 64'(busy), 64'd0);
    chk("reset_done", 64'(done), 64'd0);
    chk("reset_rnd_ready", 64'(rnd_ready), 64'd0);
    chk("reset_sb_x", {56'd0, sb_x_1, sb_x_0}, 64'd0);
    chk("reset_out", state_out_0 | state_out_1, 64'd0);
    rst = 1'b0;

    // Identity nibbles with zero mask.
    do_op(ID_IN, 64'h0, 0, 0, 0, 20, 1, ID_RES);

    // Reset after five issues: the operation is dropped, with no done and cleared outputs.
    mode = 0;
    step();
    start = 1'b1; state_in_0 = ID_IN; state_in_1 = 64'h0123456789ABCDEF; phase = 0;
    repeat (5) step();
    rst = 1'b1;
    #1;
    chk("abort_busy", 64'(busy), 64'd0);
    chk("abort_out0", state_out_0, 64'd0);
    chk("abort_out1", state_out_1, 64'd0);
    d_seen = 0;
    repeat (3) begin step(); if (done) d_seen = 1; end
    rst = 1'b0;
    repeat (2) begin step(); if (done) d_seen = 1; end
    chk("abort_no_done", 64'(d_seen), 64'd0);
    do_op(ID_IN, 64'h0, 0, 0, 0, 20, 1, ID_RES);

    // Zero shares with rnd held at 0.
    do_op(64'h0, 64'h0, 0, 1, 0, 20, 1, ZERO_RES);

    // Random masking of the identity state.
    repeat (3) begin
      msk = {$urandom, $urandom};
      do_op(ID_IN ^ msk, msk, 0, 0, 0, 20, 1, ID_RES);
    end

    // Randomness stalls: the 1,0,0,1 pattern gives 16 bubbles. Then a toggling pattern.
    msk = {$urandom, $urandom};
    do_op(ID_IN ^ msk, msk, 1, 0, 0, 36, 1, ID_RES);
    do_op(ID_IN, 64'h0, 3, 0, 0, 35, 1, ID_RES);

    // Start pulses while busy and in the DONE cycle are ignored.
    msk = {$urandom, $urandom};
    do_op(ID_IN ^ msk, msk, 0, 0, 1, 20, 1, ID_RES);
    repeat (3) step();
    chk("hold_after_ignored_start", state_out_0 ^ state_out_1, ID_RES);
    do_op(64'h0, 64'h0, 0, 0, 0, 20, 1, ZERO_RES);

    // Random data with random stalls, checked cycle by cycle by the model.
    repeat (4) begin
      do_op({$urandom, $urandom}, {$urandom, $urandom}, 2, 0, 0, -1, 0, 64'h0);
    end
    repeat (3) step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/present_sbox_layer_ctrl.md
Name: present_sbox_layer_ctrl

Overview:
Sequencer that runs the full PRESENT substitution layer on a 2-share masked 64-bit state using one shared DOM-AND masked 4-bit S-box instance. The instance is external and connected through the sb_* ports.
- Issues the 16 nibbles serially, one per cycle, each with one fresh random bit.
- Stalls issue while randomness is unavailable.
- Collects S-box outputs after the fixed pipeline latency, reassembles both output shares and signals completion.
- Sits between the round-key/permutation logic and the masked S-box core.

Parameters:
SBOX_LAT, 3, register stages of the masked S-box from sb_x/sb_r to sb_y.
NIB, 16, nibbles per state; fixed at 16 for PRESENT and not to be overridden.

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
start  in  1  1-cycle request; sampled only in IDLE
state_in_0  in  64  share 0 of input state
state_in_1  in  64  share 1 of input state
rnd  in  1  fresh random bit
rnd_valid  in  1  rnd is usable this cycle
rnd_ready  out  1  rnd is consumed this cycle
sb_x_0  out  4  share 0 nibble to S-box; bit k drives xk_0
sb_x_1  out  4  share 1 nibble to S-box; bit k drives xk_1
sb_r  out  1  random bit to S-box
sb_y_0  in  4  S-box output share 0; bit k is Yk_0
sb_y_1  in  4  S-box output share 1; bit k is Yk_1
busy  out  1  operation in progress
done  out  1  1-cycle completion pulse
state_out_0  out  64  share 0 result
state_out_1  out  64  share 1 result

Behaviour:
Clock and reset:
- One clock, clk.
- Reset rst is asynchronous and active-high.
- On reset: all registers clear, FSM=IDLE, busy=0, done=0, rnd_ready=0, sb_x_0=sb_x_1=0, sb_r=0, state_out_0=state_out_1=0, issue/collect counters=0, valid pipeline cleared.

Nibble mapping and share handling:
- Nibble i is bits [4i+3:4i], i=0..15.
- Shares are never combined inside this block.
- state_out_s nibble i = sb_y_s collected for issued nibble i.

FSM:
- IDLE: busy=0. On start=1, latch state_in_0/1 into local regs, clear counters, go to ISSUE. busy=1 from the next cycle.
- ISSUE, each cycle:
  - If rnd_valid=1: drive sb_x_s = latched nibble issue_cnt, sb_r=rnd, rnd_ready=1. Push valid=1 and index issue_cnt into a SBOX_LAT-deep shift pipeline. Increment issue_cnt.
  - If rnd_valid=0 (bubble): sb_x_0=sb_x_1=0, sb_r=0, rnd_ready=0, push valid=0. Share data is never driven during a bubble.
  - After the issue with issue_cnt=15, go to DRAIN. Outputs return to zero.
- DRAIN: rnd_ready=0, sb_x=0, sb_r=0. Go to DONE when collect_cnt reaches 16.
- DONE: done=1 for exactly 1 cycle; busy stays 1 during it. Then go to IDLE with busy=0.

Collection (runs in ISSUE and DRAIN):
- When the pipeline output valid=1, capture sb_y_0/sb_y_1 into result nibble [index] and increment collect_cnt.
- A nibble issued in cycle t is captured at the end of cycle t+SBOX_LAT.
- Issue and collect of different nibbles may occur in the same cycle.

Result outputs:
- state_out_0/1 are updated only when DONE is entered.
- They hold the last result until the next DONE or reset. Partial results are never visible.

Latency:
- No bubbles: start in cycle 0, ISSUE cycles 1..16, done in cycle 17+SBOX_LAT (cycle 20 at default).
- Each bubble adds exactly 1 cycle.

Boundary conditions:
- start while busy or in DONE: ignored; no effect on latched data.
- start in the same cycle done is high: ignored.
- rnd_valid toggling every cycle: order preserved, exactly 16 issues.
- rnd_valid=0 for any length: no timeout, ISSUE holds.
- rst mid-operation: immediate abort; no done pulse; state_out=0.
- Each rnd bit is used for exactly one nibble. The S-box reuses that nibble's bit internally one cycle later.

Test Plan:
1. Reset mid-ISSUE (after 5 issues) -> busy=0, done never pulses, state_out=0. A new start then completes normally at cycle 20.
2. Zero shares: state_in_0=0, state_in_1=0, rnd_valid=1, rnd=0 -> done at cycle 20. state_out_0 XOR state_out_1 = 0xCCCCCCCCCCCCCCCC.
3. Identity-nibble state: state_in_0=0xFEDCBA9876543210, state_in_1=0, rnd_valid=1, random rnd -> XOR of shares = 0x21748FE3DA09B65C, rnd_ready high for exactly 16 cycles.
4. Random masking: state_in_1=random M, state_in_0=0xFEDCBA9876543210^M -> XOR of outputs = 0x21748FE3DA09B65C, independent of M.
5. Randomness stalls: rnd_valid pattern 1,0,0,1 repeating -> sb_x=0 on every bubble cycle, exactly 16 rnd_ready pulses, done at cycle 20 + number of bubbles, result as in scenario 3.
6. start pulsed during busy and in the DONE cycle -> ignored. state_out reflects only the first operation; the next start is accepted in IDLE.
